// File: rtl/sig_dac_tx.sv
// sig_dac_tx: samples the mixer bus on a timer tick and shifts it to a 12-bit SPI DAC
module sig_dac_tx #(
  parameter int CLK_DIV    = 1,
  parameter int SAMPLE_DIV = 50,
  parameter int SIGNED_IN  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] sig,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        sample_tick,
  output logic        busy,
  output logic        overrun
);
  localparam int TW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_d;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt, cnt_d;
  logic [4:0] hp, hp_d, hp_n;
  logic [15:0] frame, frame_d;
  logic tick, sync_d, sclk_d, din_d, tick_d, ovr_d;
  assign tick = en && timer == TW'(SAMPLE_DIV - 1);
  assign hp_n = hp + 5'd1;
  // sample timer: held at zero while disabled, wraps every SAMPLE_DIV cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else timer <= (!en || tick) ? '0 : timer + 1'b1;
  // next-state and next-output logic; frame bit 15 is always zero so din starts low
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hp_d    = hp;
    frame_d = frame;
    sync_d  = dac_sync_n;
    sclk_d  = dac_sclk;
    din_d   = dac_din;
    tick_d  = 1'b0;
    ovr_d   = overrun | (tick && state != IDLE);
    if (state == IDLE) begin
      if (tick) begin
        state_d = SHIFT;
        cnt_d   = '0;
        hp_d    = '0;
        frame_d = (sig ^ {SIGNED_IN != 0, 15'b0}) >> 4;
        sync_d  = 1'b0;
        sclk_d  = 1'b1;
        din_d   = 1'b0;
        tick_d  = 1'b1;
      end
    end else if (state == SHIFT) begin
      cnt_d = cnt == CW'(CLK_DIV - 1) ? '0 : cnt + 1'b1;
      if (cnt == CW'(CLK_DIV - 1)) begin
        if (hp == 5'd31) begin
          state_d = DONE;
          sync_d  = 1'b1;
          sclk_d  = 1'b1;
          din_d   = 1'b0;
        end else begin
          hp_d   = hp_n;
          sclk_d = ~hp_n[0];
          din_d  = hp_n[0] ? dac_din : frame[~hp_n[4:1]];
        end
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hp          <= '0;
      frame       <= '0;
      dac_sync_n  <= 1'b1;
      dac_sclk    <= 1'b1;
      dac_din     <= 1'b0;
      sample_tick <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      hp          <= hp_d;
      frame       <= frame_d;
      dac_sync_n  <= sync_d;
      dac_sclk    <= sclk_d;
      dac_din     <= din_d;
      sample_tick <= tick_d;
      busy        <= state_d != IDLE;
      overrun     <= ovr_d;
    end
endmodule

// File: tb/tb_sig_dac_tx.sv
// tb_sig_dac_tx: three configurations of sig_dac_tx checked against an elapsed-time model
module tb_sig_dac_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] en = '0;
  logic [15:0] sig [3];
  logic [2:0] sync_n, sclk, din, tk, busy, ovr;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int n [3] = '{0, 0, 0};
  int el [3] = '{-1, -1, -1};
  logic [15:0] fr [3] = '{16'h0, 16'h0, 16'h0};
  logic [2:0] m_tk = '0, m_ovr = '0;
  logic [15:0] sh [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] last [3] = '{16'h0, 16'h0, 16'h0};
  int fl [3] = '{0, 0, 0};
  int lastfl [3] = '{0, 0, 0};
  logic [2:0] p_sclk = '1, p_sync = '1, p_din = '0;

  sig_dac_tx u0 (.clk(clk), .rst_n(rst_n), .en(en[0]), .sig(sig[0]), .dac_sync_n(sync_n[0]),
    .dac_sclk(sclk[0]), .dac_din(din[0]), .sample_tick(tk[0]), .busy(busy[0]), .overrun(ovr[0]));
  sig_dac_tx #(.CLK_DIV(2), .SAMPLE_DIV(80), .SIGNED_IN(1)) u1 (.clk(clk), .rst_n(rst_n),
    .en(en[1]), .sig(sig[1]), .dac_sync_n(sync_n[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
    .sample_tick(tk[1]), .busy(busy[1]), .overrun(ovr[1]));
  sig_dac_tx #(.SAMPLE_DIV(20)) u2 (.clk(clk), .rst_n(rst_n), .en(en[2]), .sig(sig[2]),
    .dac_sync_n(sync_n[2]), .dac_sclk(sclk[2]), .dac_din(din[2]), .sample_tick(tk[2]),
    .busy(busy[2]), .overrun(ovr[2]));

  always #5 clk = ~clk;

  function automatic int dv(int i);
    return i == 1 ? 2 : 1;
  endfunction

  function automatic int sv(int i);
    return i == 0 ? 50 : i == 1 ? 80 : 20;
  endfunction

  function automatic logic [15:0] mframe(int i, logic [15:0] s);
    logic [15:0] v;
    v = i == 1 ? s + 16'h8000 : s;
    return {4'h0, v[15:4]};
  endfunction

  function automatic logic mtick(int i);
    return en[i] && (n[i] + 1) % sv(i) == 0;
  endfunction

  // expected {sync_n, sclk, din, sample_tick, busy, overrun} from time elapsed since capture
  function automatic logic [5:0] mout(int i);
    int hp;
    if (el[i] >= 0 && el[i] < 32 * dv(i)) begin
      hp = el[i] / dv(i);
      return {1'b0, hp % 2 == 0, fr[i][15 - hp / 2], m_tk[i], 1'b1, m_ovr[i]};
    end
    return {1'b1, 1'b1, 1'b0, m_tk[i], el[i] >= 0, m_ovr[i]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: en-high edge count drives ticks, elapsed cycles since capture drives the frame
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 3; i++)
      if (!rst_n) begin
        n[i] <= 0;
        el[i] <= -1;
        fr[i] <= '0;
        m_tk[i] <= 1'b0;
        m_ovr[i] <= 1'b0;
      end else begin
        n[i] <= en[i] ? n[i] + 1 : 0;
        m_tk[i] <= mtick(i) && el[i] < 0;
        m_ovr[i] <= m_ovr[i] || (mtick(i) && el[i] >= 0);
        if (mtick(i) && el[i] < 0) begin
          el[i] <= 0;
          fr[i] <= mframe(i, sig[i]);
        end else el[i] <= (el[i] >= 0 && el[i] < 32 * dv(i)) ? el[i] + 1 : -1;
      end

  // per-cycle comparison plus a DAC-side deserialiser sampling din on sclk falling edges
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d outputs", i), {sync_n[i], sclk[i], din[i], tk[i], busy[i], ovr[i]}, mout(i));
      if (p_sclk[i] && !sclk[i] && !sync_n[i]) begin
        sh[i] <= {sh[i][14:0], p_din[i]};
        fl[i] <= fl[i] + 1;
      end
      if (p_sync[i] && !sync_n[i]) begin
        sh[i] <= '0;
        fl[i] <= 0;
      end
      if (!p_sync[i] && sync_n[i]) begin
        last[i] <= sh[i];
        lastfl[i] <= fl[i];
      end
    end
    p_sclk <= sclk;
    p_sync <= sync_n;
    p_din <= din;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tick(input int i, output int t);
    for (int k = 0; k < 400 && !tk[i]; k++) step();
    if (!tk[i]) chk($sformatf("u%0d tick timeout", i), 0, 1);
    t = cyc;
  endtask

  task automatic wait_idle(input int i, output int lo, output int bz);
    lo = 0;
    bz = 0;
    for (int k = 0; k < 300 && busy[i]; k++) begin
      bz++;
      if (!sync_n[i]) lo++;
      step();
    end
    if (busy[i]) chk($sformatf("u%0d idle timeout", i), 0, 1);
  endtask

  initial begin
    int r, t1, t2, t3, lo, bz, cnt;
    sig = '{16'hABCD, 16'h8000, 16'hABCD};
    repeat (3) step();
    chk("reset outputs", {sync_n, sclk, din, tk, busy, ovr}, 18'b111_111_000_000_000_000);
    en[0] = 1'b1;
    rst_n = 1'b1;
    r = cyc;
    wait_tick(0, t1);
    chk("first tick delay", t1 - r, 50);
    wait_idle(0, lo, bz);
    chk("sync low cycles", lo, 32);
    chk("busy cycles", bz, 33);
    chk("frame ABCD", last[0], 16'h0ABC);
    chk("falling edges", lastfl[0], 16);
    sig[0] = 16'h1230;
    wait_tick(0, t2);
    chk("sample period", t2 - t1, 50);
    repeat (6) step();
    sig[0] = 16'hFFFF;
    wait_idle(0, lo, bz);
    chk("frame held 1230", last[0], 16'h0123);
    wait_tick(0, t3);
    repeat (10) step();
    en[0] = 1'b0;
    wait_idle(0, lo, bz);
    chk("en drop frame", last[0], 16'h0FFF);
    chk("en drop edges", lastfl[0], 16);
    chk("en drop sync low", lo, 22);
    cnt = 0;
    repeat (200) begin
      step();
      if (tk[0] || !sync_n[0]) cnt++;
    end
    chk("quiet while disabled", cnt, 0);
    en[0] = 1'b1;
    r = cyc;
    wait_tick(0, t1);
    chk("tick after enable", t1 - r, 50);
    en[0] = 1'b0;
    wait_idle(0, lo, bz);
    en[1] = 1'b1;
    r = cyc;
    wait_tick(1, t1);
    chk("signed first tick", t1 - r, 80);
    wait_idle(1, lo, bz);
    chk("div2 sync low", lo, 64);
    chk("div2 busy", bz, 65);
    chk("signed 8000", last[1], 16'h0000);
    chk("div2 edges", lastfl[1], 16);
    sig[1] = 16'h7FFF;
    wait_tick(1, t2);
    chk("signed period", t2 - t1, 80);
    wait_idle(1, lo, bz);
    chk("signed 7FFF", last[1], 16'h0FFF);
    sig[1] = 16'h0000;
    wait_tick(1, t2);
    wait_idle(1, lo, bz);
    chk("signed 0000", last[1], 16'h0800);
    en[1] = 1'b0;
    en[2] = 1'b1;
    r = cyc;
    wait_tick(2, t1);
    chk("short first tick", t1 - r, 20);
    while (cyc < r + 39) step();
    chk("overrun before", ovr[2], 0);
    step();
    chk("overrun set", ovr[2], 1);
    chk("dropped tick", tk[2], 0);
    wait_tick(2, t3);
    chk("tick after overrun", t3 - r, 60);
    chk("overrun sticky", ovr[2], 1);
    wait_idle(2, lo, bz);
    chk("frame after overrun", last[2], 16'h0ABC);
    en[2] = 1'b0;
    sig[0] = 16'h5A5A;
    en[0] = 1'b1;
    wait_tick(0, t1);
    repeat (10) step();
    chk("pre-reset din", {sync_n[0], din[0], busy[0]}, 3'b011);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset", {sync_n[0], sclk[0], din[0], busy[0], ovr[2]}, 5'b11000);
    repeat (3) step();
    rst_n = 1'b1;
    r = cyc;
    wait_tick(0, t1);
    chk("tick after reset", t1 - r, 50);
    wait_idle(0, lo, bz);
    chk("post-reset sync low", lo, 32);
    chk("post-reset frame", last[0], 16'h05A5);
    chk("post-reset edges", lastfl[0], 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
